// File: rtl/video_sync_monitor.sv
// Measures HSYNC/VSYNC timing (line period, sync widths, lines per frame) and tracks lock.
// Results and MEAS_VALID appear 2 PCLK after the VSYNC assertion is sampled; no backpressure.
module video_sync_monitor #(
  parameter bit HS_ACTIVE_LOW  = 1'b1,
  parameter bit VS_ACTIVE_LOW  = 1'b1,
  parameter int CNT_W          = 12,
  parameter int LOCK_FRAMES    = 3,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             PCLK,
  input  logic             RESET,
  input  logic             HSYNC,
  input  logic             VSYNC,
  output logic [CNT_W-1:0] H_TOTAL,
  output logic [CNT_W-1:0] H_SYNC_W,
  output logic [CNT_W-1:0] V_TOTAL,
  output logic [CNT_W-1:0] V_SYNC_W,
  output logic             MEAS_VALID,
  output logic             LOCKED,
  output logic             LOST
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam int               IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int               MATCH_W    = $clog2(LOCK_FRAMES + 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_FRAMES);
  localparam logic [MATCH_W-1:0] MATCH_PRE  = MATCH_W'(LOCK_FRAMES - 1);

  typedef struct packed {
    logic [CNT_W-1:0] h_total;
    logic [CNT_W-1:0] h_sync_w;
    logic [CNT_W-1:0] v_total;
    logic [CNT_W-1:0] v_sync_w;
  } meas_t;

  typedef enum logic [1:0] {SEARCH, MEASURE, TRACK} state_t;

  logic              hs, hs_q, vs, vs_q;
  logic              hs_rise, hs_fall, vs_rise, timeout;
  logic [CNT_W-1:0]  h_cnt, h_per, hw_cnt, hw_lat, v_cnt, vw_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              frame_end;
  meas_t             snap, ref_meas;
  logic              snap_ok;
  logic [MATCH_W-1:0] match_cnt;
  state_t            state;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign hs_rise = hs & ~hs_q;
  assign hs_fall = ~hs & hs_q;
  assign vs_rise = vs & ~vs_q;
  // A fresh line edge always rescues the idle counter, even on its last count.
  assign timeout = ~hs_rise & (idle_cnt == IDLE_LAST);

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      hs        <= 1'b0;
      hs_q      <= 1'b0;
      vs        <= 1'b0;
      vs_q      <= 1'b0;
      h_cnt     <= '0;
      h_per     <= '0;
      hw_cnt    <= '0;
      hw_lat    <= '0;
      v_cnt     <= '0;
      vw_cnt    <= '0;
      idle_cnt  <= '0;
      frame_end <= 1'b0;
      snap      <= '0;
    end else begin
      hs   <= HSYNC ^ HS_ACTIVE_LOW;
      hs_q <= hs;
      vs   <= VSYNC ^ VS_ACTIVE_LOW;
      vs_q <= vs;

      if (hs_rise) begin
        h_cnt  <= CNT_W'(1);
        h_per  <= h_cnt;
        hw_cnt <= CNT_W'(1);
      end else begin
        h_cnt <= sat_inc(h_cnt);
        if (hs) hw_cnt <= sat_inc(hw_cnt);
      end
      if (hs_fall) hw_lat <= hw_cnt;

      // A line edge coincident with the frame edge is line 1 of the new frame.
      if (vs_rise) begin
        v_cnt  <= hs_rise ? CNT_W'(1) : '0;
        vw_cnt <= hs_rise ? CNT_W'(1) : '0;
      end else if (hs_rise) begin
        v_cnt <= sat_inc(v_cnt);
        if (vs) vw_cnt <= sat_inc(vw_cnt);
      end

      if (hs_rise)      idle_cnt <= IDLE_W'(1);
      else if (timeout) idle_cnt <= '0;
      else              idle_cnt <= idle_cnt + IDLE_W'(1);

      frame_end <= vs_rise & ~timeout;
      if (vs_rise) snap <= '{h_total: h_per, h_sync_w: hw_lat, v_total: v_cnt, v_sync_w: vw_cnt};
    end
  end

  assign snap_ok = (snap.h_total != CNT_MAX) && (snap.h_sync_w != CNT_MAX) &&
                   (snap.v_total != CNT_MAX) && (snap.v_sync_w != CNT_MAX);

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      state      <= SEARCH;
      H_TOTAL    <= '0;
      H_SYNC_W   <= '0;
      V_TOTAL    <= '0;
      V_SYNC_W   <= '0;
      MEAS_VALID <= 1'b0;
      LOCKED     <= 1'b0;
      LOST       <= 1'b0;
      ref_meas   <= '0;
      match_cnt  <= '0;
    end else begin
      MEAS_VALID <= 1'b0;
      LOST       <= 1'b0;
      if (timeout) begin
        // Timeout also swallows a frame end that is in flight this cycle.
        LOST      <= 1'b1;
        LOCKED    <= 1'b0;
        H_TOTAL   <= '0;
        H_SYNC_W  <= '0;
        V_TOTAL   <= '0;
        V_SYNC_W  <= '0;
        match_cnt <= '0;
        state     <= SEARCH;
      end else if (frame_end) begin
        unique case (state)
          SEARCH: state <= MEASURE;
          MEASURE, TRACK: begin
            H_TOTAL    <= snap.h_total;
            H_SYNC_W   <= snap.h_sync_w;
            V_TOTAL    <= snap.v_total;
            V_SYNC_W   <= snap.v_sync_w;
            MEAS_VALID <= 1'b1;
            state      <= TRACK;
            if (!snap_ok) begin
              match_cnt <= '0;
              LOCKED    <= 1'b0;
              ref_meas  <= snap;
            end else if (state == TRACK && snap == ref_meas) begin
              if (match_cnt != MATCH_LOCK) match_cnt <= match_cnt + MATCH_W'(1);
              if (match_cnt >= MATCH_PRE) LOCKED <= 1'b1;
            end else begin
              match_cnt <= MATCH_W'(1);
              LOCKED    <= 1'b0;
              ref_meas  <= snap;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_sync_monitor.sv
// Bench for video_sync_monitor: frame tables drive three instances, a scoreboard checks each MEAS_VALID.
module tb_video_sync_monitor;

  localparam int W = 12;

  typedef struct {
    int h, hsw, v, vsw, act;
    bit mv;
    int ht, hw, vt, vw;
    bit lk;
  } rec_t;

  typedef struct {
    int ht, hw, vt, vw;
    bit lk;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0;
  logic hs_a = 1'b0, vs_a = 1'b0, hs_b = 1'b0, vs_b = 1'b0;

  logic [W-1:0] a_ht, a_hw, a_vt, a_vw, p_ht, p_hw, p_vt, p_vw, b_ht, b_hw, b_vt, b_vw;
  logic a_mv, a_lk, a_lost, p_mv, p_lk, p_lost, b_mv, b_lk, b_lost;

  // Active-low instance (the common case) with a short timeout.
  video_sync_monitor #(.TIMEOUT_CYCLES(500)) u_dut (
    .PCLK(clk), .RESET(rst_a), .HSYNC(~hs_a), .VSYNC(~vs_a),
    .H_TOTAL(a_ht), .H_SYNC_W(a_hw), .V_TOTAL(a_vt), .V_SYNC_W(a_vw),
    .MEAS_VALID(a_mv), .LOCKED(a_lk), .LOST(a_lost));

  video_sync_monitor #(.HS_ACTIVE_LOW(1'b0), .VS_ACTIVE_LOW(1'b0), .TIMEOUT_CYCLES(500)) u_pos (
    .PCLK(clk), .RESET(rst_a), .HSYNC(hs_a), .VSYNC(vs_a),
    .H_TOTAL(p_ht), .H_SYNC_W(p_hw), .V_TOTAL(p_vt), .V_SYNC_W(p_vw),
    .MEAS_VALID(p_mv), .LOCKED(p_lk), .LOST(p_lost));

  video_sync_monitor u_big (
    .PCLK(clk), .RESET(rst_b), .HSYNC(~hs_b), .VSYNC(~vs_b),
    .H_TOTAL(b_ht), .H_SYNC_W(b_hw), .V_TOTAL(b_vt), .V_SYNC_W(b_vw),
    .MEAS_VALID(b_mv), .LOCKED(b_lk), .LOST(b_lost));

  exp_t q_a[$], q_p[$], q_b[$];
  int cyc = 0;
  int errors = 0, checks = 0;
  int last_hs_a = 0;
  int lost_n_a = 0, lost_n_p = 0, lost_cyc_a = -1, lost_cyc_p = -1;
  bit phase_c = 1'b0, big_lock_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic on_mv(input int id, input int ht, input int hw, input int vt, input int vw,
                       input int lk);
    exp_t e;
    int sz;
    string n;
    n  = (id == 0) ? "a" : (id == 1) ? "p" : "b";
    sz = (id == 0) ? q_a.size() : (id == 1) ? q_p.size() : q_b.size();
    chk({n, "_meas_valid_expected"}, int'(sz > 0), 1);
    if (sz > 0) begin
      if (id == 0)      e = q_a.pop_front();
      else if (id == 1) e = q_p.pop_front();
      else              e = q_b.pop_front();
      chk({n, "_h_total"}, ht, e.ht);
      chk({n, "_h_sync_w"}, hw, e.hw);
      chk({n, "_v_total"}, vt, e.vt);
      chk({n, "_v_sync_w"}, vw, e.vw);
      chk({n, "_locked"}, lk, int'(e.lk));
      chk({n, "_mv_cycle"}, cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (a_mv) on_mv(0, int'(a_ht), int'(a_hw), int'(a_vt), int'(a_vw), int'(a_lk));
    if (p_mv) on_mv(1, int'(p_ht), int'(p_hw), int'(p_vt), int'(p_vw), int'(p_lk));
    if (b_mv) on_mv(2, int'(b_ht), int'(b_hw), int'(b_vt), int'(b_vw), int'(b_lk));
    if (a_lost) begin lost_n_a++; lost_cyc_a = cyc; end
    if (p_lost) begin lost_n_p++; lost_cyc_p = cyc; end
    if (phase_c && b_lk) big_lock_seen = 1'b1;
  end

  function automatic rec_t mk(input int h, input int hsw, input int v, input int vsw, input int act,
                              input bit mv, input int eht, input int ehw, input int evt,
                              input int evw, input bit lk);
    rec_t r;
    r.h = h; r.hsw = hsw; r.v = v; r.vsw = vsw; r.act = act; r.mv = mv;
    r.ht = eht; r.hw = ehw; r.vt = evt; r.vw = evw; r.lk = lk;
    return r;
  endfunction

  // Lines first..last of a frame; sync pulses start each line, VSYNC covers whole lines.
  task automatic drive_lines(input int grp, input int h, input int hsw, input int vsw,
                             input int first, input int last);
    for (int l = first; l <= last; l++) begin
      for (int p = 0; p < h; p++) begin
        @(negedge clk);
        if (grp == 0) begin
          hs_a = (p < hsw);
          vs_a = (l < vsw);
          if (p == 0) last_hs_a = cyc + 1;
        end else begin
          hs_b = (p < hsw);
          vs_b = (l < vsw);
        end
      end
    end
  endtask

  // Called at the negedge of the last pixel; the next frame's VSYNC is sampled 2 edges later.
  task automatic push_exp(input int grp, input rec_t r);
    exp_t e;
    e.ht = r.ht; e.hw = r.hw; e.vt = r.vt; e.vw = r.vw; e.lk = r.lk;
    e.cyc = cyc + 4;
    if (grp == 0) begin
      q_a.push_back(e);
      q_p.push_back(e);
    end else begin
      q_b.push_back(e);
    end
  endtask

  task automatic timeout_seq();
    int n0a, n0p, lh;
    n0a = lost_n_a;
    n0p = lost_n_p;
    lh  = last_hs_a;
    repeat (520) begin
      @(negedge clk);
      hs_a = 1'b0;
      vs_a = 1'b0;
    end
    chk("a_lost_count", lost_n_a - n0a, 1);
    chk("p_lost_count", lost_n_p - n0p, 1);
    chk("a_lost_cycle", lost_cyc_a, lh + 500);
    chk("p_lost_cycle", lost_cyc_p, lh + 500);
    chk("a_locked_after_lost", int'(a_lk), 0);
    chk("p_locked_after_lost", int'(p_lk), 0);
    chk("a_h_total_after_lost", int'(a_ht), 0);
    chk("a_v_total_after_lost", int'(a_vt), 0);
    chk("p_h_sync_w_after_lost", int'(p_hw), 0);
    chk("p_v_sync_w_after_lost", int'(p_vw), 0);
  endtask

  task automatic reset_seq();
    int n0;
    n0 = lost_n_a;
    chk("a_locked_before_reset", int'(a_lk), 1);
    @(negedge clk);
    #2 rst_a = 1'b1;
    #1;
    chk("a_locked_async_reset", int'(a_lk), 0);
    chk("a_h_total_async_reset", int'(a_ht), 0);
    chk("a_v_total_async_reset", int'(a_vt), 0);
    chk("p_locked_async_reset", int'(p_lk), 0);
    chk("p_h_sync_w_async_reset", int'(p_hw), 0);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("a_no_lost_on_reset", lost_n_a - n0, 0);
    chk("a_lost_low_after_reset", int'(a_lost), 0);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rec_t ta[17];
    rec_t tbr[6];

    for (int i = 0; i < 17; i++) ta[i] = mk(20, 3, 10, 2, 0, 1, 20, 3, 10, 2, 0);
    ta[2].lk  = 1;
    ta[3].lk  = 1;
    ta[4]     = mk(20, 3, 11, 2, 0, 1, 20, 3, 11, 2, 0);
    ta[7].lk  = 1;
    ta[8]     = mk(20, 3, 10, 2, 1, 0, 0, 0, 0, 0, 0);
    ta[11].lk = 1;
    ta[12].lk = 1;
    ta[13]    = mk(20, 3, 10, 2, 2, 0, 0, 0, 0, 0, 0);
    ta[16].lk = 1;

    tbr[0] = mk(800, 96, 10, 2, 0, 1, 800, 96, 10, 2, 0);
    tbr[1] = tbr[0];
    tbr[2] = mk(800, 96, 10, 2, 0, 1, 800, 96, 10, 2, 1);
    for (int i = 3; i < 6; i++) tbr[i] = mk(5000, 96, 2, 1, 0, 1, 4095, 96, 2, 1, 0);

    #1 rst_a = 1'b1;
    rst_b = 1'b1;
    #2;
    chk("reset_a_h_total", int'(a_ht), 0);
    chk("reset_a_v_sync_w", int'(a_vw), 0);
    chk("reset_a_meas_valid", int'(a_mv), 0);
    chk("reset_a_locked", int'(a_lk), 0);
    chk("reset_a_lost", int'(a_lost), 0);
    chk("reset_b_v_total", int'(b_vt), 0);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    fork
      begin : thread_a
        for (int i = 0; i < 17; i++) begin
          case (ta[i].act)
            1: begin
              drive_lines(0, ta[i].h, ta[i].hsw, ta[i].vsw, 0, ta[i].v - 1);
              timeout_seq();
            end
            2: begin
              drive_lines(0, ta[i].h, ta[i].hsw, ta[i].vsw, 0, 3);
              reset_seq();
              drive_lines(0, ta[i].h, ta[i].hsw, ta[i].vsw, 4, ta[i].v - 1);
            end
            default: begin
              drive_lines(0, ta[i].h, ta[i].hsw, ta[i].vsw, 0, ta[i].v - 1);
              if (ta[i].mv) push_exp(0, ta[i]);
            end
          endcase
        end
        drive_lines(0, 20, 3, 2, 0, 0);
        repeat (8) @(negedge clk);
      end
      begin : thread_b
        for (int i = 0; i < 3; i++) begin
          drive_lines(1, tbr[i].h, tbr[i].hsw, tbr[i].vsw, 0, tbr[i].v - 1);
          push_exp(1, tbr[i]);
        end
        drive_lines(1, 800, 96, 2, 0, 0);
        @(negedge clk);
        hs_b = 1'b0;
        vs_b = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_b = 1'b1;
        #1;
        chk("b_locked_async_reset", int'(b_lk), 0);
        chk("b_h_total_async_reset", int'(b_ht), 0);
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        phase_c = 1'b1;
        for (int i = 3; i < 6; i++) begin
          drive_lines(1, tbr[i].h, tbr[i].hsw, tbr[i].vsw, 0, tbr[i].v - 1);
          push_exp(1, tbr[i]);
        end
        drive_lines(1, 5000, 96, 1, 0, 0);
        repeat (8) @(negedge clk);
      end
    join

    chk("a_queue_drained", q_a.size(), 0);
    chk("p_queue_drained", q_p.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    chk("b_never_locked_when_saturated", int'(big_lock_seen), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_sync_monitor.md
Name: video_sync_monitor

Overview:
Receive-side counterpart to the 480p sync generator. It samples HSYNC/VSYNC in the PCLK domain and measures the horizontal period, horizontal sync width, vertical period and vertical sync width. It declares LOCKED once consecutive frames match, and flags loss of sync. It is used in loopback self-check of our timing generator and as the front end of the future capture path.

Parameters:
HS_ACTIVE_LOW, 1, HSYNC polarity (1 = asserted when low; 640x480@60 uses negative sync)
VS_ACTIVE_LOW, 1, VSYNC polarity
CNT_W, 12, width of all measurement counters and outputs
LOCK_FRAMES, 3, number of consecutive identical frame measurements required for LOCKED (min 2)
TIMEOUT_CYCLES, 1000000, PCLK cycles without an HSYNC assertion edge before sync is declared lost

Ports:
PCLK  in  1  pixel clock; single clock domain, all logic on posedge
RESET  in  1  asynchronous, active-high reset
HSYNC  in  1  horizontal sync input, PCLK-synchronous
VSYNC  in  1  vertical sync input, PCLK-synchronous
H_TOTAL  out  CNT_W  PCLK cycles per line
H_SYNC_W  out  CNT_W  PCLK cycles HSYNC is asserted
V_TOTAL  out  CNT_W  lines per frame
V_SYNC_W  out  CNT_W  lines with VSYNC asserted
MEAS_VALID  out  1  one-cycle pulse when the four outputs update
LOCKED  out  1  timing stable
LOST  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, RESET=1): all outputs 0, all counters 0, FSM in SEARCH.
- Input stage: HSYNC/VSYNC registered once and normalised to active-high (XOR with polarity parameter) giving hs/vs. Previous values are held in a second register.
- Assertion edge = active now and inactive previous. Deassertion edge = the opposite.
- h_cnt: reset to 1 on each hs assertion edge, otherwise increments, saturating at all-ones.
  - On the next hs assertion edge, h_cnt is the line period.
- hw_cnt: counts cycles with hs active, reset on each hs assertion edge. Its value is latched on the hs deassertion edge.
- Line events are hs assertion edges. v_cnt counts line events since the last vs assertion edge.
  - A line event in the same cycle as a vs assertion edge belongs to the new frame, so v_cnt restarts at 1.
  - vw_cnt counts line events while vs is active, including a coincident one.
- Period, width and line counters saturate at all-ones. Any saturated value marks the frame invalid.
- FSM:
  - SEARCH: wait for the first vs assertion edge; discard the partial frame; go to MEASURE.
  - MEASURE: at the next vs assertion edge, publish the measurements, assert MEAS_VALID, store them as the reference, set match count to 1, go to TRACK.
  - TRACK: at each vs assertion edge, publish the measurements and pulse MEAS_VALID.
    - All four values equal the reference and the frame is valid: match count increments, saturating at LOCK_FRAMES.
    - Otherwise: match count resets to 1, the reference is replaced, and LOCKED drops in the same cycle as MEAS_VALID.
    - LOCKED rises in the MEAS_VALID cycle where match count reaches LOCK_FRAMES.
  - An invalid frame in TRACK: outputs still publish, match count goes to 0, LOCKED goes to 0.
- Horizontal values published per frame are those of the last completed line before the vs edge. H_TOTAL/H_SYNC_W are not updated per line.
- Latency: MEAS_VALID and the new output values appear 2 PCLK cycles after the PCLK edge at which the VSYNC assertion is first sampled.
- Timeout: an idle counter resets on each hs assertion edge and otherwise increments.
  - At TIMEOUT_CYCLES: LOST pulses 1 cycle, LOCKED goes to 0, measurement outputs clear to 0, FSM goes to SEARCH, idle counter restarts.
  - Any state, including MEASURE, times out.
- Simultaneous events:
  - Timeout and a vs edge in the same cycle: timeout wins, and no MEAS_VALID is issued.
  - An hs edge with a vs edge: handled as above.
- RESET mid-frame: immediate return to reset values, with no LOST pulse.

Test Plan:
- 640x480@60 stimulus (800/96 cycles, 525 lines, VSYNC 2 lines, both active low) -> H_TOTAL=800, H_SYNC_W=96, V_TOTAL=525, V_SYNC_W=2. MEAS_VALID once per frame. LOCKED rises at the 3rd MEAS_VALID after the first full frame.
- Small synthetic timing (H 20/3, V 10/2) locked, then one frame with 11 lines -> that MEAS_VALID shows V_TOTAL=11 and LOCKED=0. LOCKED re-asserts 2 frames after returning to 10 lines.
- Stop HSYNC toggling while locked (TIMEOUT_CYCLES=500) -> LOST pulse exactly 500 cycles after the last assertion edge. Outputs and LOCKED go to 0. Relock needs SEARCH + LOCK_FRAMES frames.
- HS_ACTIVE_LOW=0 with inverted stimulus -> identical measured values to the active-low run.
- RESET pulse mid-frame while LOCKED -> all outputs 0 asynchronously with no LOST pulse. The first partial frame after release produces no MEAS_VALID.
- HSYNC period 5000 with CNT_W=12 -> H_TOTAL=4095 published, LOCKED never asserts.
